band_readout_sequencer: RTL and testbench

Drives the select input of the 16:1 band mux and streams the 16 band values (12-bit each) out over an 8-bit valid/ready byte interface. It runs once per spectrogram frame. A start pulse launches a readout. Each band goes out as two bytes: the band index plus the value MSBs, then the value LSBs. It sits between the band-energy register bank/mux and the chip's 8-bit output pins.

---
 rtl/band_readout_sequencer.sv | 118 +++++++++++
 tb/tb_band_readout_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_readout_sequencer.sv
// Band readout sequencer: walks the band mux once per frame and streams each
// 12-bit band value out as two bytes over a valid/ready interface.
//   byte 0: {band[3:0], value[11:8]}
//   byte 1: value[7:0]
module band_readout_sequencer #(
    parameter int unsigned NUM_BANDS     = 16,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [3:0]  mux_sel,
    input  logic [11:0] mux_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam logic [3:0] LastBand   = 4'(NUM_BANDS - 1);
    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StSendHi,
        StSendLo
    } state_e;

    state_e      state_q;
    logic [3:0]  band_q;
    logic [3:0]  settle_cnt_q;
    logic [11:0] cap_q;
    logic        xfer;

    assign xfer = out_valid & out_ready;
    assign busy = (state_q != StIdle);

    // Sequencer FSM; every output except busy is a register updated here.
    // out_valid/out_data are registered, so they rise one cycle after the
    // FSM enters SEND_HI (the capture edge); no transfer can occur before then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            band_q       <= 4'd0;
            settle_cnt_q <= 4'd0;
            cap_q        <= 12'd0;
            mux_sel      <= 4'd0;
            out_data     <= 8'd0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            done <= 1'b0;

            // Any start outside IDLE is dropped but remembered, including the
            // cycle of the final LO transfer.
            if (start && (state_q != StIdle)) begin
                overrun <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        band_q       <= 4'd0;
                        mux_sel      <= 4'd0;
                        settle_cnt_q <= SettleLoad;
                        overrun      <= 1'b0;
                        state_q      <= StSettle;
                    end
                end

                StSettle: begin
                    // mux_sel has been stable since entry; capture on the last count
                    if (settle_cnt_q == 4'd1) begin
                        cap_q   <= mux_data;
                        state_q <= StSendHi;
                    end
                    settle_cnt_q <= settle_cnt_q - 4'd1;
                end

                StSendHi: begin
                    if (xfer) begin
                        out_data <= cap_q[7:0];
                        state_q  <= StSendLo;
                    end else begin
                        // Re-asserting the same values holds them under back-pressure
                        out_valid <= 1'b1;
                        out_data  <= {band_q, cap_q[11:8]};
                    end
                end

                StSendLo: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        if (band_q == LastBand) begin
                            mux_sel <= 4'd0;
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            band_q       <= band_q + 4'd1;
                            mux_sel      <= band_q + 4'd1;
                            settle_cnt_q <= SettleLoad;
                            state_q      <= StSettle;
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_readout_sequencer.sv
// Directed bench for band_readout_sequencer: reset, full frame, back-pressure,
// capture timing (SETTLE_CYCLES=3 instance), overrun and mid-frame reset.
module tb_band_readout_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  mux_sel;
    logic [11:0] mux_data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    logic        start2;
    logic [3:0]  mux_sel2;
    logic [11:0] mux_data2;
    logic [7:0]  out_data2;
    logic        out_valid2;
    logic        out_ready2;
    logic        busy2;
    logic        done2;
    logic        overrun2;

    logic [11:0] band_val [16];
    int          errors   = 0;
    int          checks   = 0;
    int          done_cnt = 0;
    int          d0;

    always #5 clk = ~clk;

    // Band mux model for the main instance
    assign mux_data = band_val[mux_sel];

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    band_readout_sequencer #(
        .NUM_BANDS    (16),
        .SETTLE_CYCLES(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mux_sel  (mux_sel),
        .mux_data (mux_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    band_readout_sequencer #(
        .NUM_BANDS    (16),
        .SETTLE_CYCLES(3)
    ) dut_slow (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start2),
        .mux_sel  (mux_sel2),
        .mux_data (mux_data2),
        .out_data (out_data2),
        .out_valid(out_valid2),
        .out_ready(out_ready2),
        .busy     (busy2),
        .done     (done2),
        .overrun  (overrun2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input bit lo);
        logic [3:0]  kk;
        logic [11:0] v;
        kk = 4'(k);
        v  = band_val[kk];
        if (lo) return v[7:0];
        return {kk, v[11:8]};
    endfunction

    // Takes the next byte off the main instance (out_ready must be 1);
    // returns at the negedge following the transfer edge.
    task automatic get_byte(input string tag, input logic [7:0] exp);
        for (int i = 0; i < 40; i++) begin
            if (out_valid && out_ready) begin
                check(tag, {24'd0, out_data}, {24'd0, exp});
                @(negedge clk);
                return;
            end
            @(negedge clk);
        end
        check({tag, " timeout"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic run_bytes(input string tag, input int first, input int last);
        for (int b = first; b <= last; b++) begin
            get_byte($sformatf("%s byte%0d", tag, b), exp_byte(b / 2, (b % 2) == 1));
        end
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (out_valid) return;
            @(negedge clk);
        end
        check({tag, " timeout"}, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b1;
        out_ready  = 1'b1;
        start2     = 1'b0;
        out_ready2 = 1'b1;
        mux_data2  = 12'h555;
        for (int k = 0; k < 16; k++) band_val[k] = 12'h100 + 12'(k);

        // 1. Reset with start held high, then idle
        #1;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst out_data", {24'd0, out_data}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst overrun", {31'd0, overrun}, 32'd0);
        check("rst mux_sel", {28'd0, mux_sel}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst hold busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle out_valid", {31'd0, out_valid}, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);
        check("idle mux_sel", {28'd0, mux_sel}, 32'd0);

        // 2. Full frame, no back-pressure, first valid two cycles after start
        d0 = done_cnt;
        pulse_start();
        check("t2 busy", {31'd0, busy}, 32'd1);
        check("t2 valid n+1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t2 valid n+2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t2 valid n+3", {31'd0, out_valid}, 32'd1);
        check("t2 first byte", {24'd0, out_data}, 32'h01);
        run_bytes("t2", 0, 31);
        check("t2 done", {31'd0, done}, 32'd1);
        check("t2 busy end", {31'd0, busy}, 32'd0);
        check("t2 mux_sel end", {28'd0, mux_sel}, 32'd0);
        @(negedge clk);
        check("t2 done low", {31'd0, done}, 32'd0);
        check("t2 done count", done_cnt - d0, 32'd1);

        // 3. Back-pressure on band 3 HI; start during last LO transfer
        band_val[3] = 12'hABC;
        pulse_start();
        run_bytes("t3", 0, 5);
        out_ready = 1'b0;
        wait_valid("t3 wait");
        for (int i = 0; i < 5; i++) begin
            check("t3 hold data", {24'd0, out_data}, 32'h3A);
            check("t3 hold sel", {28'd0, mux_sel}, 32'd3);
            check("t3 hold valid", {31'd0, out_valid}, 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        get_byte("t3 hi", 8'h3A);
        get_byte("t3 lo", 8'hBC);
        run_bytes("t3", 8, 30);
        check("t3 overrun before", {31'd0, overrun}, 32'd0);
        start = 1'b1;
        get_byte("t3 last", exp_byte(15, 1'b1));
        start = 1'b0;
        check("t3 done", {31'd0, done}, 32'd1);
        check("t3 no restart", {31'd0, busy}, 32'd0);
        check("t3 overrun last", {31'd0, overrun}, 32'd1);

        // 5. Overrun during band 5; next accepted start clears it
        @(negedge clk);
        pulse_start();
        check("t5 overrun clr", {31'd0, overrun}, 32'd0);
        run_bytes("t5", 0, 9);
        check("t5 sel band5", {28'd0, mux_sel}, 32'd5);
        pulse_start();
        check("t5 overrun set", {31'd0, overrun}, 32'd1);
        check("t5 busy", {31'd0, busy}, 32'd1);
        run_bytes("t5", 10, 31);
        check("t5 done", {31'd0, done}, 32'd1);
        repeat (3) @(negedge clk);
        check("t5 overrun sticky", {31'd0, overrun}, 32'd1);
        check("t5 idle", {31'd0, busy}, 32'd0);
        pulse_start();
        check("t5 overrun clr2", {31'd0, overrun}, 32'd0);
        check("t5 restart busy", {31'd0, busy}, 32'd1);

        // 6. Reset in SEND_LO of band 7
        run_bytes("t6", 0, 14);
        check("t6 in lo valid", {31'd0, out_valid}, 32'd1);
        check("t6 in lo sel", {28'd0, mux_sel}, 32'd7);
        check("t6 in lo data", {24'd0, out_data}, {24'd0, exp_byte(7, 1'b1)});
        rst_n = 1'b0;
        #1;
        check("t6 async valid", {31'd0, out_valid}, 32'd0);
        check("t6 async busy", {31'd0, busy}, 32'd0);
        check("t6 async sel", {28'd0, mux_sel}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6 quiet", {31'd0, out_valid}, 32'd0);
        pulse_start();
        get_byte("t6 new hi", 8'h01);
        get_byte("t6 new lo", 8'h00);

        // 4. Capture timing with SETTLE_CYCLES=3 (second instance)
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (3) @(negedge clk);
        check("t4 valid n+3", {31'd0, out_valid2}, 32'd0);
        @(negedge clk);
        check("t4 valid n+4", {31'd0, out_valid2}, 32'd1);
        check("t4 b0 hi", {24'd0, out_data2}, 32'h05);
        @(negedge clk);
        check("t4 b0 lo", {24'd0, out_data2}, 32'h55);
        @(negedge clk);
        check("t4 sel change", {28'd0, mux_sel2}, 32'd1);
        check("t4 settle valid", {31'd0, out_valid2}, 32'd0);
        @(negedge clk);
        mux_data2 = 12'h777;
        @(negedge clk);
        @(negedge clk);
        check("t4 valid m+3", {31'd0, out_valid2}, 32'd0);
        @(negedge clk);
        check("t4 valid m+4", {31'd0, out_valid2}, 32'd1);
        check("t4 b1 hi", {24'd0, out_data2}, 32'h17);
        @(negedge clk);
        check("t4 b1 lo", {24'd0, out_data2}, 32'h77);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
